hwr_lock_mgr: RTL and testbench

- Hardware lock manager that serves CMD_LOCK (0x04) and CMD_UNLOCK (0x06) commands from accelerators and returns 8-bit ACK codes.
- Sits behind the HWR_LOCK_ID (0x15) stream port of the manager.
- Parametrised successor of the fixed 8-bit, reject-only lock scheme: configurable lock count, lock-ID width and accelerator-ID width.
- Optional wait mode parks busy requests and grants them in FIFO order on unlock.

---
 rtl/hwr_lock_mgr.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_hwr_lock_mgr.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwr_lock_mgr.sv
// -----------------------------------------------------------------------------
// hwr_lock_mgr
//
// Hardware lock manager behind the HWR_LOCK_ID stream port. Accelerators send
// CMD_LOCK / CMD_UNLOCK commands. The manager returns 8-bit ACK codes on the
// ACK stream. With WAIT_MODE = 1, a lock request that hits a busy lock is
// parked in a FIFO-ordered wait table. On unlock, the oldest waiter for that
// lock is granted the lock.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   cmd_in_valid     command valid
//   cmd_in_ready     command accepted when valid & ready (IDLE only)
//   cmd_in_data      [7:0] command code, [8 +: LOCK_ID_BITS] lock ID
//   cmd_in_src       requesting accelerator
//   ack_out_valid    ACK valid (held until ack_out_ready)
//   ack_out_ready    ACK consumed
//   ack_out_data     [7:0] ACK code, [8 +: LOCK_ID_BITS] lock ID, rest 0
//   ack_out_dest     destination accelerator
//   locked_mask      bit i set while lock i is held
//   wait_count       occupied wait-table entries (0 when WAIT_MODE = 0)
//   err_count        saturating count of dropped or illegal commands
// -----------------------------------------------------------------------------
module hwr_lock_mgr #(
    parameter int NUM_LOCKS    = 16,
    parameter int LOCK_ID_BITS = 8,
    parameter int ACC_BITS     = 4,
    parameter int WAIT_MODE    = 0,
    parameter int WAIT_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               cmd_in_valid,
    output logic                               cmd_in_ready,
    input  logic [63:0]                        cmd_in_data,
    input  logic [ACC_BITS-1:0]                cmd_in_src,
    output logic                               ack_out_valid,
    input  logic                               ack_out_ready,
    output logic [63:0]                        ack_out_data,
    output logic [ACC_BITS-1:0]                ack_out_dest,
    output logic [NUM_LOCKS-1:0]               locked_mask,
    output logic [$clog2(WAIT_DEPTH+1)-1:0]    wait_count,
    output logic [15:0]                        err_count
);

    localparam int IDX_BITS  = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
    localparam int WCNT_BITS = $clog2(WAIT_DEPTH + 1);

    localparam logic [7:0] CMD_LOCK   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK = 8'h06;
    localparam logic [7:0] ACK_OK     = 8'h01;
    localparam logic [7:0] ACK_REJECT = 8'h00;

    localparam logic [LOCK_ID_BITS:0] NUM_LOCKS_CMP = (LOCK_ID_BITS + 1)'(NUM_LOCKS);
    localparam logic [WCNT_BITS-1:0]  WAIT_FULL_CNT = WCNT_BITS'(WAIT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SEND
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic [7:0]                code_q, code_d;
    logic [LOCK_ID_BITS-1:0]   lid_q, lid_d;
    logic [ACC_BITS-1:0]       src_q, src_d;

    logic [NUM_LOCKS-1:0]      held_q, held_d;
    logic [ACC_BITS-1:0]       owner_q [NUM_LOCKS];
    logic [ACC_BITS-1:0]       owner_d [NUM_LOCKS];

    // Wait table: entries [0, wcnt_q) are live, index 0 is the oldest.
    // With WAIT_MODE = 0 it is never written, so it reduces to constants.
    logic [ACC_BITS-1:0]       wt_src_q [WAIT_DEPTH];
    logic [ACC_BITS-1:0]       wt_src_d [WAIT_DEPTH];
    logic [LOCK_ID_BITS-1:0]   wt_id_q  [WAIT_DEPTH];
    logic [LOCK_ID_BITS-1:0]   wt_id_d  [WAIT_DEPTH];
    logic [WCNT_BITS-1:0]      wcnt_q, wcnt_d;

    logic                      ack_valid_q, ack_valid_d;
    logic [63:0]               ack_data_q, ack_data_d;
    logic [ACC_BITS-1:0]       ack_dest_q, ack_dest_d;
    logic [15:0]               err_q, err_d;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic                      lid_ok;
    logic [IDX_BITS-1:0]       lid_idx;
    logic                      wt_full;
    logic                      hit_found;
    int                        hit_pos;
    logic [ACC_BITS-1:0]       hit_src;
    logic                      inc_err;

    // Only the lock-ID field and the code are meaningful in a command.
    logic unused_data_bits;
    assign unused_data_bits = ^cmd_in_data[63:8+LOCK_ID_BITS];

    assign lid_ok  = ({1'b0, lid_q} < NUM_LOCKS_CMP);
    assign lid_idx = lid_q[IDX_BITS-1:0];
    assign wt_full = (wcnt_q == WAIT_FULL_CNT);

    function automatic logic [63:0] make_ack(input logic [7:0]              code,
                                             input logic [LOCK_ID_BITS-1:0] id);
        logic [63:0] d;
        d                    = '0;
        d[7:0]               = code;
        d[8 +: LOCK_ID_BITS] = id;
        return d;
    endfunction

    // Oldest waiter for the latched lock ID. The lowest live index wins.
    always_comb begin
        hit_found = 1'b0;
        hit_pos   = 0;
        hit_src   = '0;
        for (int i = 0; i < WAIT_DEPTH; i++) begin
            if (!hit_found && (i < int'(wcnt_q)) && (wt_id_q[i] == lid_q)) begin
                hit_found = 1'b1;
                hit_pos   = i;
                hit_src   = wt_src_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        lid_d       = lid_q;
        src_d       = src_q;
        held_d      = held_q;
        owner_d     = owner_q;
        wt_src_d    = wt_src_q;
        wt_id_d     = wt_id_q;
        wcnt_d      = wcnt_q;
        ack_valid_d = ack_valid_q;
        ack_data_d  = ack_data_q;
        ack_dest_d  = ack_dest_q;
        err_d       = err_q;
        inc_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_in_valid && ready_q) begin
                    code_d  = cmd_in_data[7:0];
                    lid_d   = cmd_in_data[8 +: LOCK_ID_BITS];
                    src_d   = cmd_in_src;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                if (code_q == CMD_LOCK) begin
                    if (!lid_ok) begin
                        inc_err     = 1'b1;
                        ack_valid_d = 1'b1;
                        ack_data_d  = make_ack(ACK_REJECT, lid_q);
                        ack_dest_d  = src_q;
                        state_d     = ST_SEND;
                    end else if (!held_q[lid_idx]) begin
                        held_d[lid_idx]  = 1'b1;
                        owner_d[lid_idx] = src_q;
                        ack_valid_d      = 1'b1;
                        ack_data_d       = make_ack(ACK_OK, lid_q);
                        ack_dest_d       = src_q;
                        state_d          = ST_SEND;
                    end else if ((WAIT_MODE != 0) && (owner_q[lid_idx] != src_q) && !wt_full) begin
                        // Park at the tail; the ACK comes with the later grant.
                        for (int i = 0; i < WAIT_DEPTH; i++) begin
                            if (i == int'(wcnt_q)) begin
                                wt_src_d[i] = src_q;
                                wt_id_d[i]  = lid_q;
                            end
                        end
                        wcnt_d = wcnt_q + 1'b1;
                    end else begin
                        // Busy with no room to wait, or a re-entrant request.
                        ack_valid_d = 1'b1;
                        ack_data_d  = make_ack(ACK_REJECT, lid_q);
                        ack_dest_d  = src_q;
                        state_d     = ST_SEND;
                    end
                end else if (code_q == CMD_UNLOCK) begin
                    if (!lid_ok || !held_q[lid_idx] || (owner_q[lid_idx] != src_q)) begin
                        inc_err = 1'b1;
                    end else if ((WAIT_MODE != 0) && hit_found) begin
                        // Ownership passes straight to the oldest waiter, so
                        // the lock never appears free in between.
                        owner_d[lid_idx] = hit_src;
                        for (int j = 0; j < WAIT_DEPTH - 1; j++) begin
                            if (j >= hit_pos) begin
                                wt_src_d[j] = wt_src_q[j+1];
                                wt_id_d[j]  = wt_id_q[j+1];
                            end
                        end
                        wt_src_d[WAIT_DEPTH-1] = '0;
                        wt_id_d[WAIT_DEPTH-1]  = '0;
                        wcnt_d      = wcnt_q - 1'b1;
                        ack_valid_d = 1'b1;
                        ack_data_d  = make_ack(ACK_OK, lid_q);
                        ack_dest_d  = hit_src;
                        state_d     = ST_SEND;
                    end else begin
                        held_d[lid_idx] = 1'b0;
                    end
                end else begin
                    inc_err = 1'b1;
                end
            end

            ST_SEND: begin
                if (ack_out_ready) begin
                    ack_valid_d = 1'b0;
                    ack_data_d  = '0;
                    ack_dest_d  = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (inc_err && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end

        // Ready is registered, so it is high exactly in the IDLE cycles.
        ready_d = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    // NOTE: the owner and wait tables are reset too, so no stale owner or waiter survives a reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            code_q      <= '0;
            lid_q       <= '0;
            src_q       <= '0;
            held_q      <= '0;
            owner_q     <= '{default: '0};
            wt_src_q    <= '{default: '0};
            wt_id_q     <= '{default: '0};
            wcnt_q      <= '0;
            ack_valid_q <= 1'b0;
            ack_data_q  <= '0;
            ack_dest_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            code_q      <= code_d;
            lid_q       <= lid_d;
            src_q       <= src_d;
            held_q      <= held_d;
            owner_q     <= owner_d;
            wt_src_q    <= wt_src_d;
            wt_id_q     <= wt_id_d;
            wcnt_q      <= wcnt_d;
            ack_valid_q <= ack_valid_d;
            ack_data_q  <= ack_data_d;
            ack_dest_q  <= ack_dest_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign cmd_in_ready  = ready_q;
    assign ack_out_valid = ack_valid_q;
    assign ack_out_data  = ack_data_q;
    assign ack_out_dest  = ack_dest_q;
    assign locked_mask   = held_q;
    assign wait_count    = (WAIT_MODE != 0) ? wcnt_q : '0;
    assign err_count     = err_q;

endmodule

// File: tb/tb_hwr_lock_mgr.sv
// -----------------------------------------------------------------------------
// tb_hwr_lock_mgr
//
// Directed bench for hwr_lock_mgr. It uses two instances:
//   u_dut0  WAIT_MODE = 0 (reject-only)
//   u_dut1  WAIT_MODE = 1, WAIT_DEPTH = 2 (FIFO wait table)
// 'dsel' picks which instance the stimulus tasks drive and observe.
// -----------------------------------------------------------------------------
module tb_hwr_lock_mgr;

    logic clk;
    logic rstn;

    // Instance 0 signals
    logic        cmd_valid0, cmd_ready0, ack_valid0, ack_ready0;
    logic [63:0] cmd_data0, ack_data0;
    logic [3:0]  cmd_src0, ack_dest0;
    logic [15:0] mask0;
    logic [3:0]  wcnt0;
    logic [15:0] err0;

    // Instance 1 signals
    logic        cmd_valid1, cmd_ready1, ack_valid1, ack_ready1;
    logic [63:0] cmd_data1, ack_data1;
    logic [3:0]  cmd_src1, ack_dest1;
    logic [15:0] mask1;
    logic [1:0]  wcnt1;
    logic [15:0] err1;

    int tests_run;
    int tests_failed;

    logic        dsel;
    logic        obs_ready, obs_valid;
    logic [63:0] obs_data;
    logic [3:0]  obs_dest;

    assign obs_ready = dsel ? cmd_ready1 : cmd_ready0;
    assign obs_valid = dsel ? ack_valid1 : ack_valid0;
    assign obs_data  = dsel ? ack_data1  : ack_data0;
    assign obs_dest  = dsel ? ack_dest1  : ack_dest0;

    hwr_lock_mgr #(
        .NUM_LOCKS(16), .LOCK_ID_BITS(8), .ACC_BITS(4), .WAIT_MODE(0), .WAIT_DEPTH(8)
    ) u_dut0 (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_in_valid  (cmd_valid0),
        .cmd_in_ready  (cmd_ready0),
        .cmd_in_data   (cmd_data0),
        .cmd_in_src    (cmd_src0),
        .ack_out_valid (ack_valid0),
        .ack_out_ready (ack_ready0),
        .ack_out_data  (ack_data0),
        .ack_out_dest  (ack_dest0),
        .locked_mask   (mask0),
        .wait_count    (wcnt0),
        .err_count     (err0)
    );

    hwr_lock_mgr #(
        .NUM_LOCKS(16), .LOCK_ID_BITS(8), .ACC_BITS(4), .WAIT_MODE(1), .WAIT_DEPTH(2)
    ) u_dut1 (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_in_valid  (cmd_valid1),
        .cmd_in_ready  (cmd_ready1),
        .cmd_in_data   (cmd_data1),
        .cmd_in_src    (cmd_src1),
        .ack_out_valid (ack_valid1),
        .ack_out_ready (ack_ready1),
        .ack_out_data  (ack_data1),
        .ack_out_dest  (ack_dest1),
        .locked_mask   (mask1),
        .wait_count    (wcnt1),
        .err_count     (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests run %0d", tests_run);
        $fatal(1, "time limit reached");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic v, input logic [63:0] d, input logic [3:0] s);
        if (dsel) begin
            cmd_valid1 = v; cmd_data1 = d; cmd_src1 = s;
        end else begin
            cmd_valid0 = v; cmd_data0 = d; cmd_src0 = s;
        end
    endtask

    task automatic set_ack_ready(input logic r);
        if (dsel) ack_ready1 = r;
        else      ack_ready0 = r;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] code, input logic [7:0] id);
        return {48'h0, id, code};
    endfunction

    // Present one command and complete its handshake. Returns #1 into cycle N+1.
    task automatic issue(input string tag, input logic [63:0] data, input logic [3:0] src);
        int n;
        n = 0;
        while (!obs_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!obs_ready) check({tag, "_rdy"}, {63'h0, obs_ready}, 64'h1);
        drive_cmd(1'b1, data, src);
        @(posedge clk); #1;
        drive_cmd(1'b0, 64'h0, 4'h0);
    endtask

    // ACK must be absent in N+1, present in N+2, then handshake once.
    task automatic expect_ack(input string tag, input logic [63:0] data, input logic [3:0] dest);
        check({tag, "_lat1"}, {63'h0, obs_valid}, 64'h0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {63'h0, obs_valid}, 64'h1);
        check({tag, "_data"},  obs_data, data);
        check({tag, "_dest"},  {60'h0, obs_dest}, {60'h0, dest});
        set_ack_ready(1'b1);
        @(posedge clk); #1;
        set_ack_ready(1'b0);
        check({tag, "_drop"}, {63'h0, obs_valid}, 64'h0);
    endtask

    // No ACK, and back in IDLE (ready) in N+2.
    task automatic expect_noack(input string tag);
        @(posedge clk); #1;
        check({tag, "_noack"}, {63'h0, obs_valid}, 64'h0);
        check({tag, "_ready"}, {63'h0, obs_ready}, 64'h1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        dsel         = 1'b0;
        rstn         = 1'b0;
        cmd_valid0 = 1'b0; cmd_data0 = '0; cmd_src0 = '0; ack_ready0 = 1'b0;
        cmd_valid1 = 1'b0; cmd_data1 = '0; cmd_src1 = '0; ack_ready1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {63'h0, cmd_ready0}, 64'h0);
        check("rst_valid",  {63'h0, ack_valid0}, 64'h0);
        check("rst_data",   ack_data0, 64'h0);
        check("rst_dest",   {60'h0, ack_dest0}, 64'h0);
        check("rst_mask",   {48'h0, mask0}, 64'h0);
        check("rst_err",    {48'h0, err0}, 64'h0);
        check("rst_wcnt1",  {62'h0, wcnt1}, 64'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_rise", {63'h0, cmd_ready0}, 64'h1);

        // ---------------- reject-only instance ----------------
        dsel = 1'b0;
        issue("lock5_a3", mk(8'h04, 8'd5), 4'd3);
        check("lock5_mask_n1", {48'h0, mask0}, 64'h0);
        expect_ack("lock5_a3", 64'h0000_0000_0000_0501, 4'd3);
        check("lock5_mask", {48'h0, mask0}, 64'h20);

        issue("busy_a7", mk(8'h04, 8'd5), 4'd7);
        expect_ack("busy_a7", 64'h500, 4'd7);
        check("busy_wcnt0", {60'h0, wcnt0}, 64'h0);

        issue("unl_nonown", mk(8'h06, 8'd5), 4'd7);
        expect_noack("unl_nonown");
        check("unl_nonown_err",  {48'h0, err0}, 64'd1);
        check("unl_nonown_mask", {48'h0, mask0}, 64'h20);

        issue("reentrant", mk(8'h04, 8'd5), 4'd3);
        expect_ack("reentrant", 64'h500, 4'd3);
        check("reentrant_err", {48'h0, err0}, 64'd1);

        issue("bad_id16", mk(8'h04, 8'd16), 4'd2);
        expect_ack("bad_id16", 64'h1000, 4'd2);
        check("bad_id16_err", {48'h0, err0}, 64'd2);

        issue("bad_code", mk(8'h09, 8'd1), 4'd2);
        expect_noack("bad_code");
        check("bad_code_err", {48'h0, err0}, 64'd3);

        issue("unl_free", mk(8'h06, 8'd3), 4'd2);
        expect_noack("unl_free");
        check("unl_free_err", {48'h0, err0}, 64'd4);

        // Bits outside code and lock-ID fields must be ignored.
        issue("junk_bits", 64'hABCD_1234_5600_0204, 4'd1);
        expect_ack("junk_bits", 64'h201, 4'd1);
        check("junk_bits_mask", {48'h0, mask0}, 64'h24);

        // Backpressure on a grant
        issue("bp", mk(8'h04, 8'd9), 4'd6);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", {63'h0, ack_valid0}, 64'h1);
            check("bp_data",  ack_data0, 64'h901);
            check("bp_ready", {63'h0, cmd_ready0}, 64'h0);
            @(posedge clk); #1;
        end
        ack_ready0 = 1'b1;
        @(posedge clk); #1;
        ack_ready0 = 1'b0;
        check("bp_drop",     {63'h0, ack_valid0}, 64'h0);
        check("bp_rdy_back", {63'h0, cmd_ready0}, 64'h1);
        @(posedge clk); #1;
        check("bp_single",   {63'h0, ack_valid0}, 64'h0);
        check("bp_mask",     {48'h0, mask0}, 64'h224);

        issue("unl9", mk(8'h06, 8'd9), 4'd6);
        expect_noack("unl9");
        check("unl9_mask", {48'h0, mask0}, 64'h24);
        check("unl9_err",  {48'h0, err0}, 64'd4);

        // ---------------- wait-mode instance ----------------
        dsel = 1'b1;
        issue("w_lock5", mk(8'h04, 8'd5), 4'd3);
        expect_ack("w_lock5", 64'h501, 4'd3);

        issue("w_park7", mk(8'h04, 8'd5), 4'd7);
        expect_noack("w_park7");
        check("w_park7_wcnt", {62'h0, wcnt1}, 64'd1);

        issue("w_park9", mk(8'h04, 8'd5), 4'd9);
        expect_noack("w_park9");
        check("w_park9_wcnt", {62'h0, wcnt1}, 64'd2);

        issue("w_full4", mk(8'h04, 8'd5), 4'd4);
        expect_ack("w_full4", 64'h500, 4'd4);
        check("w_full4_wcnt", {62'h0, wcnt1}, 64'd2);

        issue("w_unl3", mk(8'h06, 8'd5), 4'd3);
        expect_ack("w_unl3", 64'h501, 4'd7);
        check("w_unl3_wcnt", {62'h0, wcnt1}, 64'd1);
        check("w_unl3_mask", {48'h0, mask1}, 64'h20);

        issue("w_unl7", mk(8'h06, 8'd5), 4'd7);
        expect_ack("w_unl7", 64'h501, 4'd9);
        check("w_unl7_wcnt", {62'h0, wcnt1}, 64'd0);

        issue("w_unl9", mk(8'h06, 8'd5), 4'd9);
        expect_noack("w_unl9");
        check("w_unl9_mask", {48'h0, mask1}, 64'h0);
        check("w_err",       {48'h0, err1}, 64'd0);

        // Waiter matching must follow the lock ID, not just the queue head.
        issue("w_l1", mk(8'h04, 8'd1), 4'd2);
        expect_ack("w_l1", 64'h101, 4'd2);
        issue("w_l5", mk(8'h04, 8'd5), 4'd3);
        expect_ack("w_l5", 64'h501, 4'd3);
        issue("w_p6", mk(8'h04, 8'd5), 4'd6);
        expect_noack("w_p6");
        issue("w_p7", mk(8'h04, 8'd1), 4'd7);
        expect_noack("w_p7");
        check("w_mix_wcnt", {62'h0, wcnt1}, 64'd2);
        issue("w_u1", mk(8'h06, 8'd1), 4'd2);
        expect_ack("w_u1", 64'h101, 4'd7);
        check("w_u1_wcnt", {62'h0, wcnt1}, 64'd1);
        issue("w_u5", mk(8'h06, 8'd5), 4'd3);
        expect_ack("w_u5", 64'h501, 4'd6);
        check("w_u5_wcnt", {62'h0, wcnt1}, 64'd0);
        check("w_u5_mask", {48'h0, mask1}, 64'h22);

        // ---------------- reset in SEND ----------------
        dsel = 1'b0;
        issue("rs_lock0", mk(8'h04, 8'd0), 4'd4);
        @(posedge clk); #1;
        check("rs_in_send", {63'h0, ack_valid0}, 64'h1);
        rstn = 1'b0;
        #1;
        check("rs_ready", {63'h0, cmd_ready0}, 64'h0);
        check("rs_valid", {63'h0, ack_valid0}, 64'h0);
        check("rs_data",  ack_data0, 64'h0);
        check("rs_dest",  {60'h0, ack_dest0}, 64'h0);
        check("rs_mask",  {48'h0, mask0}, 64'h0);
        check("rs_err",   {48'h0, err0}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rs_ready_low", {63'h0, cmd_ready0}, 64'h0);
        @(posedge clk); #1;
        check("rs_ready_up", {63'h0, cmd_ready0}, 64'h1);
        issue("rs_relock5", mk(8'h04, 8'd5), 4'd8);
        expect_ack("rs_relock5", 64'h501, 4'd8);
        check("rs_relock5_mask", {48'h0, mask0}, 64'h20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
